// File: rtl/uba_nxd_mon.sv
// Unibus non-existent-device monitor: arbitrates acknowledgement of each bus
// request and raises setNXD when no claimant acks within the timeout.
module uba_nxd_mon #(
    parameter int unsigned NDEV        = 8,
    parameter int unsigned CNTW        = 8,
    parameter int unsigned TIMEOUT     = 15,
    parameter int unsigned ADDRW       = 18,
    parameter int unsigned NOCLAIM_NXD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busREQI,
    input  logic [ADDRW-1:0] busADDRI,
    output logic             busACKO,
    input  logic [NDEV-1:0]  devREQ,
    input  logic [NDEV-1:0]  devACK,
    input  logic             ubaACK,
    input  logic             wruACK,
    input  logic             toLOAD,
    input  logic [CNTW-1:0]  toDATA,
    input  logic             nxdCLR,
    output logic             setNXD,
    output logic             nxdFLAG,
    output logic [ADDRW-1:0] nxdADDR,
    output logic [NDEV-1:0]  nxdDEV,
    output logic [3:0]       nxdCNT
);

    typedef enum logic [2:0] {IDLE, DLY, ACK, NXD, WAIT} stateT;

    stateT             state;
    stateT             stateNext;
    logic [NDEV-1:0]   sel;
    logic [NDEV-1:0]   selNext;
    logic [ADDRW-1:0]  addr;
    logic [CNTW-1:0]   counter;
    logic [CNTW-1:0]   toReg;
    logic              latchReq;
    logic              loadCnt;
    logic              decCnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state, datapath strobes and state-decoded outputs.
    always_comb begin
        stateNext = state;
        selNext   = '0;
        latchReq  = 1'b0;
        loadCnt   = 1'b0;
        decCnt    = 1'b0;
        busACKO   = (state == ACK);
        setNXD    = (state == NXD);
        case (state)
            IDLE: begin
                if (busREQI) begin
                    if (ubaACK || wruACK) begin
                        stateNext = ACK;
                    end else if (|devREQ) begin
                        latchReq = 1'b1;
                        selNext  = devREQ;
                        if (|(devACK & devREQ)) begin
                            stateNext = ACK;
                        end else begin
                            loadCnt   = 1'b1;
                            stateNext = DLY;
                        end
                    end else if (NOCLAIM_NXD != 0) begin
                        latchReq  = 1'b1;
                        loadCnt   = 1'b1;
                        stateNext = DLY;
                    end
                end
            end
            DLY: begin
                // Ack is tested before the zero check so a last-cycle ack wins.
                if (!busREQI)                 stateNext = IDLE;
                else if (|(devACK & sel))     stateNext = ACK;
                else if (counter != '0)       decCnt    = 1'b1;
                else                          stateNext = NXD;
            end
            ACK:     if (!busREQI) stateNext = IDLE;
            NXD:     stateNext = WAIT;
            WAIT:    if (!busREQI) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request capture, timeout counter and timeout register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= '0;
            addr    <= '0;
            counter <= '0;
            toReg   <= CNTW'(TIMEOUT);
        end else begin
            if (toLOAD) toReg <= toDATA;
            if (latchReq) begin
                sel  <= selNext;
                addr <= busADDRI;
            end
            if (loadCnt)     counter <= toReg;
            else if (decCnt) counter <= counter - 1'b1;
        end
    end

    // Sticky NXD status; a coincident clear loses to the new event.
    always_ff @(posedge clk) begin
        if (rst) begin
            nxdFLAG <= 1'b0;
            nxdADDR <= '0;
            nxdDEV  <= '0;
            nxdCNT  <= '0;
        end else if (state == NXD) begin
            nxdFLAG <= 1'b1;
            nxdADDR <= addr;
            nxdDEV  <= sel;
            if (nxdCLR)                nxdCNT <= 4'd1;
            else if (nxdCNT != 4'hF)   nxdCNT <= nxdCNT + 4'd1;
        end else if (nxdCLR) begin
            nxdFLAG <= 1'b0;
            nxdADDR <= '0;
            nxdDEV  <= '0;
            nxdCNT  <= '0;
        end
    end

endmodule

// File: tb/tb_uba_nxd_mon.sv
// Bench for uba_nxd_mon: directed scenarios plus random traffic, checked every
// cycle against a deadline-based transaction model.
module tb_uba_nxd_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busREQI = 1'b0;
    logic [17:0] busADDRI = '0;
    logic        busACKO;
    logic [7:0]  devREQ = '0;
    logic [7:0]  devACK = '0;
    logic        ubaACK = 1'b0;
    logic        wruACK = 1'b0;
    logic        toLOAD = 1'b0;
    logic [7:0]  toDATA = '0;
    logic        nxdCLR = 1'b0;
    logic        setNXD;
    logic        nxdFLAG;
    logic [17:0] nxdADDR;
    logic [7:0]  nxdDEV;
    logic [3:0]  nxdCNT;

    uba_nxd_mon #(
        .NDEV(8), .CNTW(8), .TIMEOUT(15), .ADDRW(18), .NOCLAIM_NXD(1)
    ) dut (
        .clk(clk), .rst(rst), .busREQI(busREQI), .busADDRI(busADDRI),
        .busACKO(busACKO), .devREQ(devREQ), .devACK(devACK), .ubaACK(ubaACK),
        .wruACK(wruACK), .toLOAD(toLOAD), .toDATA(toDATA), .nxdCLR(nxdCLR),
        .setNXD(setNXD), .nxdFLAG(nxdFLAG), .nxdADDR(nxdADDR), .nxdDEV(nxdDEV),
        .nxdCNT(nxdCNT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int lastPulse = -1;

    // Model: a request is "acked", "blocked" (after NXD), "pending" with an
    // absolute deadline cycle, or an NXD pulse is due.
    bit          mAck, mBlk, mPend, mPulse;
    int          mDeadline;
    logic [7:0]  mSel;
    logic [17:0] mAddr;
    int          mTo = 15;
    bit          mFlag;
    logic [17:0] mNAddr;
    logic [7:0]  mNDev;
    int          mCnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clearStatus();
        mFlag = 0; mNAddr = '0; mNDev = '0; mCnt = 0;
    endtask

    // Advance the model with the current inputs, clock once, compare outputs.
    task automatic step();
        int nTo;
        if (rst) begin
            mAck = 0; mBlk = 0; mPend = 0; mPulse = 0;
            mSel = '0; mAddr = '0; mTo = 15;
            clearStatus();
        end else begin
            nTo = toLOAD ? int'(toDATA) : mTo;
            if (mPulse) begin
                mFlag = 1; mNAddr = mAddr; mNDev = mSel;
                mCnt = nxdCLR ? 1 : (mCnt < 15 ? mCnt + 1 : 15);
                mPulse = 0; mBlk = 1;
            end else begin
                if (nxdCLR) clearStatus();
                if (mAck) mAck = busREQI;
                else if (mBlk) mBlk = busREQI;
                else if (mPend) begin
                    if (!busREQI) mPend = 0;
                    else if ((devACK & mSel) != 0) begin mPend = 0; mAck = 1; end
                    else if (cyc == mDeadline) begin mPend = 0; mPulse = 1; end
                end else if (busREQI) begin
                    if (ubaACK || wruACK) mAck = 1;
                    else if (devREQ != 0) begin
                        mSel = devREQ; mAddr = busADDRI;
                        if ((devACK & devREQ) != 0) mAck = 1;
                        else begin mPend = 1; mDeadline = cyc + 1 + mTo; end
                    end else begin
                        mSel = '0; mAddr = busADDRI;
                        mPend = 1; mDeadline = cyc + 1 + mTo;
                    end
                end
            end
            mTo = nTo;
        end
        @(posedge clk); #1;
        cyc++;
        chk("busACKO", busACKO, mAck);
        chk("setNXD", setNXD, mPulse);
        chk("nxdFLAG", nxdFLAG, mFlag);
        chk("nxdADDR", nxdADDR, mNAddr);
        chk("nxdDEV", nxdDEV, mNDev);
        chk("nxdCNT", nxdCNT, mCnt);
        if (setNXD) begin pulses++; lastPulse = cyc; end
    endtask

    task automatic quiet();
        busREQI = 0; devREQ = '0; devACK = '0; ubaACK = 0; wruACK = 0;
        toLOAD = 0; nxdCLR = 0;
    endtask

    // One unclaimed request run to NXD, optionally clearing in the NXD cycle.
    task automatic runNxd(input bit clr);
        int k;
        busREQI = 1; devREQ = '0;
        k = 0;
        while (!setNXD && k < 300) begin step(); k++; end
        if (!setNXD) chk("nxdWait", 0, 1);
        nxdCLR = clr; step(); nxdCLR = 0;
        busREQI = 0; step();
    endtask

    initial begin
        int reqCyc, p0;
        rst = 1; step(); step();
        rst = 0; quiet(); step();

        // Device claim in the request cycle.
        p0 = pulses;
        busREQI = 1; devREQ = 8'h04; devACK = 8'h04; busADDRI = 18'o123456; step();
        chk("claimAck", busACKO, 1);
        devACK = '0; repeat (3) step();
        busREQI = 0; devREQ = '0; step(); step();
        chk("claimNoNxd", pulses - p0, 0);

        // Default timeout with a held request.
        p0 = pulses; reqCyc = cyc;
        busREQI = 1; devREQ = 8'h01; busADDRI = 18'o776000;
        repeat (25) step();
        chk("defLatency", lastPulse - reqCyc, 17);
        chk("defPulses", pulses - p0, 1);
        chk("defAddr", nxdADDR, 18'o776000);
        chk("defDev", nxdDEV, 8'h01);
        busREQI = 0; devREQ = '0; step();

        // Foreign acks ignored; selected ack on the counter==0 cycle wins.
        p0 = pulses; reqCyc = cyc;
        busREQI = 1; devREQ = 8'h02; devACK = 8'h01; busADDRI = 18'o160010;
        while (cyc < reqCyc + 16) step();
        devACK = 8'h02; step();
        chk("lateAck", busACKO, 1);
        devACK = '0; step(); busREQI = 0; devREQ = '0; step();
        chk("lateNoNxd", pulses - p0, 0);

        // Programmable timeout; a load mid-DLY leaves that transaction alone.
        toLOAD = 1; toDATA = 8'd3; step(); toLOAD = 0;
        reqCyc = cyc; busREQI = 1; devREQ = '0; busADDRI = 18'o000100;
        step(); step();
        toLOAD = 1; toDATA = 8'd9; step(); toLOAD = 0;
        repeat (6) step();
        chk("progLatency", lastPulse - reqCyc, 5);
        chk("progDev", nxdDEV, 0);
        busREQI = 0; step();

        // Abort mid-DLY, then saturation and coincident clear.
        p0 = pulses; busREQI = 1; repeat (3) step();
        busREQI = 0; repeat (15) step();
        chk("abortNoNxd", pulses - p0, 0);
        toLOAD = 1; toDATA = 8'd0; step(); toLOAD = 0;
        for (int i = 0; i < 16; i++) runNxd(0);
        chk("satCnt", nxdCNT, 15);
        runNxd(1);
        chk("clrCnt", nxdCNT, 1);
        chk("clrFlag", nxdFLAG, 1);

        // Reset mid-DLY restores the default timeout.
        toLOAD = 1; toDATA = 8'd5; step(); toLOAD = 0;
        busREQI = 1; busADDRI = 18'o000200; repeat (3) step();
        rst = 1; step();
        chk("rstFlag", nxdFLAG, 0);
        rst = 0; busREQI = 0; step();
        reqCyc = cyc; busREQI = 1; repeat (20) step();
        chk("rstLatency", lastPulse - reqCyc, 17);
        busREQI = 0; step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            if (busREQI) begin
                if ($urandom_range(7) == 0) busREQI = 0;
            end else if ($urandom_range(2) == 0) begin
                busREQI = 1;
                busADDRI = 18'($urandom);
                devREQ = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            end
            devACK = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
            ubaACK = ($urandom_range(15) == 0);
            wruACK = ($urandom_range(15) == 0);
            toLOAD = ($urandom_range(19) == 0);
            toDATA = 8'($urandom_range(10));
            nxdCLR = ($urandom_range(29) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
